pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-flow controller that owns the 16-bit program counter and sequences instruction fetch for the microcontroller core. It replaces free-running increment with a fetch/wait FSM. The FSM supports sequential advance, absolute jump, zero/non-zero conditional branch, call/return through a small hardware return stack, halt/resume and pipeline stall. It sits between the instruction memory (fetch_en, pc) and the decoder (instr_valid, op, target, zero_flag).

Parameters:
PC_W, 16, program counter width
RESET_VEC, 16'h0000, PC value loaded on reset
STACK_DEPTH, 4, return-stack entries (power of two, 2..16)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
stall  input  1  freeze request from datapath/memory
instr_valid  input  1  decoder presents a valid op/target this cycle
op  input  3  flow opcode: 000 NEXT, 001 JMP, 010 BRZ, 011 BRNZ, 100 CALL, 101 RET, 110 HALT, 111 reserved
target  input  PC_W  jump/branch/call destination
zero_flag  input  1  ALU zero flag, sampled with instr_valid
resume  input  1  leave HALT state
pc  output  PC_W  current program counter
fetch_en  output  1  instruction-memory read strobe for address pc
pc_upd  output  1  one-cycle pulse: pc changed on the previous edge
halted  output  1  high while in HALT
stack_ovf  output  1  sticky: CALL attempted with stack full
stack_unf  output  1  sticky: RET attempted with stack empty
state  output  2  FSM state: 00 FETCH, 01 WAIT, 10 HALT

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_VEC, state=FETCH, stack pointer=0 (empty), stack contents don't-care, pc_upd=0, stack_ovf=0, stack_unf=0. After release, halted=0 and fetch_en=1 in the first cycle unless stall is high.
- Outputs fetch_en, halted and state decode combinationally from the state register. pc, pc_upd and the sticky flags are registered.
- fetch_en = (state==FETCH) && !stall.
- FETCH: if !stall, go to WAIT next edge. pc is unchanged.
- WAIT: if stall, hold. Else if instr_valid, update pc per op and go to FETCH, or to HALT for op HALT. Else hold. instr_valid is ignored in FETCH and HALT.
- Minimum throughput: 2 cycles per instruction (FETCH, then WAIT with instr_valid=1).
- pc update in WAIT (p1 = pc+1, modulo 2^PC_W; 16'hFFFF+1 = 16'h0000):
  - NEXT: p1
  - JMP: target
  - BRZ: zero_flag ? target : p1
  - BRNZ: !zero_flag ? target : p1
  - CALL, stack not full: push p1, pc=target
  - CALL, stack full: no push, pc=p1, set stack_ovf
  - RET, stack not empty: pop, pc=popped value
  - RET, stack empty: pc=p1, set stack_unf
  - HALT: pc=p1, next state HALT
  - reserved (111): treated as NEXT
- Return stack: LIFO, STACK_DEPTH entries. Full = pointer==STACK_DEPTH; empty = pointer==0. It is modified only on accepted CALL/RET in WAIT.
- HALT: pc held, fetch_en=0. resume=1 with stall=0 moves to FETCH next edge. resume with stall=1 waits.
- stall has priority over every transition and pc update in every state. A stalled cycle changes nothing.
- pc_upd is high for exactly one cycle after any edge where the pc register value changed. It stays low when a JMP/branch target equals the current pc.
- Sticky flags are cleared only by reset. The block keeps operating after they are set.
- Reset asserted mid-instruction aborts immediately. The pending op is lost and the stack is emptied.

Test Plan:
- Reset then sequential flow: RESET_VEC=0, issue NEXT three times with instr_valid in WAIT -> pc 0→1→2→3, fetch_en high every other cycle, pc_upd pulses three times.
- Branches: pc=0x0010, BRZ target 0x0100 with zero_flag=1 -> pc=0x0100. Then BRNZ target 0x0200 with zero_flag=1 -> pc=0x0101.
- Call/return: pc=0x0020, CALL 0x0400 -> pc=0x0400. RET -> pc=0x0021. Fill with 4 nested CALLs, a 5th CALL from pc=0x0500 -> pc=0x0501, stack_ovf=1. 5 RETs -> 4 correct returns, then stack_unf=1.
- Wrap and halt: JMP 0xFFFF, NEXT -> pc=0x0000. HALT -> halted=1, pc=0x0001, fetch_en=0. resume -> FETCH, fetch_en=1.
- Stall priority: in WAIT assert stall with instr_valid=1, op=JMP 0x1234 for 3 cycles -> pc, state and pc_upd unchanged. Release stall -> pc=0x1234 next edge.
- Async reset mid-op: after 2 CALLs, drop rst between clock edges -> pc=RESET_VEC immediately, state=FETCH, flags 0, subsequent RET sets stack_unf.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch.
// Each instruction takes a FETCH cycle followed by a WAIT cycle. In WAIT the
// decoder's flow opcode updates the pc. A small LIFO return stack backs
// CALL/RET. A stall input freezes every state update in every state.
module pc_sequencer #(
  parameter int unsigned     PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_VEC   = {PC_W{1'b0}},
  parameter int unsigned     STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            instr_valid,
  input  logic [2:0]      op,
  input  logic [PC_W-1:0] target,
  input  logic            zero_flag,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            pc_upd,
  output logic            halted,
  output logic            stack_ovf,
  output logic            stack_unf,
  output logic [1:0]      state
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SP_W  = IDX_W + 1;

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BRZ  = 3'b010;
  localparam logic [2:0] OP_BRNZ = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              pc_upd_q, pc_upd_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];

  logic [PC_W-1:0]   p1;
  logic              stack_full;
  logic              stack_empty;
  logic              push_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  // Sequential-advance address and return-stack status.
  always_comb begin
    p1          = pc_q + PC_W'(1);
    stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    stack_empty = (sp_q == '0);
    wr_idx      = sp_q[IDX_W-1:0];
    top_idx     = IDX_W'(sp_q - SP_W'(1));
  end

  // Next-state, pc update, stack pointer and sticky flags; stall freezes all.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT: begin
          if (instr_valid) begin
            state_d = ST_FETCH;
            pc_d    = p1;
            case (op)
              OP_JMP:  pc_d = target;
              OP_BRZ:  if (zero_flag)  pc_d = target;
              OP_BRNZ: if (!zero_flag) pc_d = target;
              OP_CALL: begin
                if (stack_full) begin
                  ovf_d = 1'b1;
                end else begin
                  push_en = 1'b1;
                  sp_d    = sp_q + SP_W'(1);
                  pc_d    = target;
                end
              end
              OP_RET: begin
                if (stack_empty) begin
                  unf_d = 1'b1;
                end else begin
                  sp_d = sp_q - SP_W'(1);
                  pc_d = stack_q[top_idx];
                end
              end
              OP_HALT: state_d = ST_HALT;
              default: ; // NEXT and the reserved opcode both advance by one
            endcase
          end
        end
        ST_HALT: if (resume) state_d = ST_FETCH;
        default: state_d = ST_FETCH;
      endcase
    end
    pc_upd_d = (pc_d != pc_q);
  end

  // Control and pc registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_VEC;
      pc_upd_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sp_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_upd_q <= pc_upd_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      sp_q     <= sp_d;
    end
  end

  // Return-stack storage; contents need no reset since the pointer is cleared.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[wr_idx] <= p1;
  end

  assign pc        = pc_q;
  assign pc_upd    = pc_upd_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
  assign state     = state_q;
  assign halted    = (state_q == ST_HALT);
  assign fetch_en  = (state_q == ST_FETCH) && !stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes expected results from
// a queue-based reference model when an instruction is accepted; a monitor
// pops and compares whenever the DUT leaves WAIT.
module tb_pc_sequencer;

  localparam int unsigned PC_W        = 16;
  localparam logic [15:0] RESET_VEC   = 16'h0000;
  localparam int unsigned STACK_DEPTH = 4;

  localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, BRZ = 3'd2, BRNZ = 3'd3,
                         CALL = 3'd4, RET = 3'd5, HALT = 3'd6, RSVD = 3'd7;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            instr_valid;
  logic [2:0]      op;
  logic [PC_W-1:0] target;
  logic            zero_flag;
  logic            resume;
  logic [PC_W-1:0] pc;
  logic            fetch_en;
  logic            pc_upd;
  logic            halted;
  logic            stack_ovf;
  logic            stack_unf;
  logic [1:0]      state;

  pc_sequencer #(.PC_W(PC_W), .RESET_VEC(RESET_VEC), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid), .op(op),
    .target(target), .zero_flag(zero_flag), .resume(resume), .pc(pc),
    .fetch_en(fetch_en), .pc_upd(pc_upd), .halted(halted), .stack_ovf(stack_ovf),
    .stack_unf(stack_unf), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic        halted;
    logic        ovf;
    logic        unf;
    logic        upd;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_stack[$];
  logic [15:0] m_pc;
  logic        m_ovf, m_unf, m_halted;
  bit          rnd_stall;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one accepted instruction, computed from the flow rules.
  task automatic model_step(input logic [2:0] o, input logic [15:0] t, input logic z);
    exp_t        e;
    logic [15:0] old;
    logic [15:0] ret_addr;
    old      = m_pc;
    ret_addr = m_pc + 16'd1;
    m_pc     = ret_addr;
    case (o)
      JMP:  m_pc = t;
      BRZ:  if (z)  m_pc = t;
      BRNZ: if (!z) m_pc = t;
      CALL: begin
        if (m_stack.size() < STACK_DEPTH) begin
          m_stack.push_back(ret_addr);
          m_pc = t;
        end else m_ovf = 1'b1;
      end
      RET: begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else m_unf = 1'b1;
      end
      HALT: m_halted = 1'b1;
      default: ;
    endcase
    e.pc = m_pc; e.halted = m_halted; e.ovf = m_ovf; e.unf = m_unf;
    e.upd = (m_pc != old);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_pc = RESET_VEC; m_ovf = 1'b0; m_unf = 1'b0; m_halted = 1'b0;
    m_stack.delete();
    exp_q.delete();
  endtask

  // Present one instruction and hold it until the DUT accepts it in WAIT.
  task automatic issue(input logic [2:0] o, input logic [15:0] t, input logic z);
    bit done = 1'b0;
    op = o; target = t; zero_flag = z; instr_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (state == 2'b01 && !stall) begin
        model_step(o, t, z);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    instr_valid = 1'b0; stall = 1'b0;
    chk("issue_accepted", 32'(done), 32'd1);
  endtask

  task automatic do_resume();
    bit done = 1'b0;
    resume = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      stall = rnd_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (state == 2'b10 && !stall) done = 1'b1;
      @(posedge clk); #1;
    end
    resume = 1'b0; stall = 1'b0;
    m_halted = 1'b0;
    #1;
    chk("resume_accepted", 32'(done), 32'd1);
    chk("resume_state", 32'(state), 32'd0);
    chk("resume_fetch_en", 32'(fetch_en), 32'd1);
  endtask

  // Monitor: compare on every instruction completion; pc must hold otherwise.
  initial begin
    logic [1:0]  prev_st;
    logic [15:0] prev_pc;
    logic        prev_rst;
    exp_t        e;
    prev_st = 2'b00; prev_pc = 16'h0; prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && prev_rst) begin
        chk("fetch_en_rule", 32'(fetch_en), 32'((state == 2'b00) && !stall));
        if (prev_st == 2'b01 && state != 2'b01) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_accept", 32'(state), 32'(prev_st));
          end else begin
            e = exp_q.pop_front();
            chk("pc", 32'(pc), 32'(e.pc));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("state_after", 32'(state), e.halted ? 32'd2 : 32'd0);
            chk("stack_ovf", 32'(stack_ovf), 32'(e.ovf));
            chk("stack_unf", 32'(stack_unf), 32'(e.unf));
            chk("pc_upd", 32'(pc_upd), 32'(e.upd));
          end
        end else begin
          chk("pc_hold", 32'(pc), 32'(prev_pc));
          chk("pc_upd_idle", 32'(pc_upd), 32'd0);
        end
      end
      prev_st = state; prev_pc = pc; prev_rst = rst;
    end
  end

  initial begin
    logic [2:0]  ro;
    logic [15:0] rt;
    rst = 1'b1; stall = 1'b0; instr_valid = 1'b0; op = 3'd0; target = 16'h0;
    zero_flag = 1'b0; resume = 1'b0; rnd_stall = 1'b0;
    model_reset();

    #1 rst = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'(RESET_VEC));
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc_upd", 32'(pc_upd), 32'd0);
    chk("rst_ovf", 32'(stack_ovf), 32'd0);
    chk("rst_unf", 32'(stack_unf), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    chk("rel_fetch_en", 32'(fetch_en), 32'd1);
    chk("rel_halted", 32'(halted), 32'd0);

    // Sequential flow
    repeat (3) issue(NEXT, 16'h0, 1'b0);
    chk("seq_pc", 32'(pc), 32'h3);

    // Branches
    issue(JMP,  16'h0010, 1'b0);
    issue(BRZ,  16'h0100, 1'b1);
    issue(BRNZ, 16'h0200, 1'b1);
    chk("brnz_not_taken", 32'(pc), 32'h0101);
    issue(BRZ,  16'h0300, 1'b0);
    issue(BRNZ, 16'h0400, 1'b0);
    issue(RSVD, 16'h9999, 1'b1);

    // Call/return, overflow and underflow
    issue(JMP,  16'h0020, 1'b0);
    issue(CALL, 16'h0400, 1'b0);
    issue(RET,  16'h0000, 1'b0);
    chk("ret_pc", 32'(pc), 32'h0021);
    issue(CALL, 16'h1000, 1'b0);
    issue(CALL, 16'h2000, 1'b0);
    issue(CALL, 16'h3000, 1'b0);
    issue(CALL, 16'h0500, 1'b0);
    issue(CALL, 16'h7000, 1'b0);
    chk("ovf_pc", 32'(pc), 32'h0501);
    chk("ovf_flag", 32'(stack_ovf), 32'd1);
    repeat (5) issue(RET, 16'h0000, 1'b0);
    chk("unf_flag", 32'(stack_unf), 32'd1);

    // Wrap and halt
    issue(JMP,  16'hFFFF, 1'b0);
    issue(NEXT, 16'h0000, 1'b0);
    chk("wrap_pc", 32'(pc), 32'h0000);
    issue(HALT, 16'h0000, 1'b0);
    chk("halt_pc", 32'(pc), 32'h0001);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_fetch_en", 32'(fetch_en), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("halt_hold_pc", 32'(pc), 32'h0001);
    do_resume();

    // Jump/branch to the current pc leaves pc_upd low
    issue(JMP, m_pc, 1'b0);
    issue(BRZ, m_pc, 1'b1);

    // Stall priority in WAIT
    op = JMP; target = 16'h1234; zero_flag = 1'b0; instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("stall_in_wait", 32'(state), 32'd1);
    stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_pc", 32'(pc), 32'(m_pc));
      chk("stall_state", 32'(state), 32'd1);
      chk("stall_upd", 32'(pc_upd), 32'd0);
      chk("stall_fetch_en", 32'(fetch_en), 32'd0);
    end
    stall = 1'b0;
    model_step(JMP, 16'h1234, 1'b0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("stall_release_pc", 32'(pc), 32'h1234);

    // Asynchronous reset mid-instruction
    issue(CALL, 16'h0800, 1'b0);
    issue(CALL, 16'h0900, 1'b0);
    @(posedge clk); #1;
    op = JMP; target = 16'h4444; instr_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_pc", 32'(pc), 32'(RESET_VEC));
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_ovf", 32'(stack_ovf), 32'd0);
    chk("arst_unf", 32'(stack_unf), 32'd0);
    chk("arst_upd", 32'(pc_upd), 32'd0);
    instr_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    issue(RET, 16'h0000, 1'b0);
    chk("arst_ret_unf", 32'(stack_unf), 32'd1);
    chk("arst_ret_pc", 32'(pc), 32'(RESET_VEC + 16'd1));

    // Randomized flow with random stalls
    rnd_stall = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (m_halted) do_resume();
      ro = 3'($urandom_range(0, 7));
      rt = ($urandom_range(0, 7) == 0) ? m_pc : 16'($urandom);
      issue(ro, rt, 1'($urandom_range(0, 1)));
    end
    rnd_stall = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
